// File: rtl/ping_sequencer.sv
// Ultrasonic ping sequencer: burst -> blank -> listen -> hold-off, with time-of-flight capture and FIFO-overflow fault.
// All outputs are registered (one cycle after the deciding inputs); there is no backpressure, FIFO_FULL forces FAULT.
module ping_sequencer #(
  parameter int HALF_CYC      = 875,
  parameter int BURST_PULSES  = 32,
  parameter int BLANK_CYCLES  = 70000,
  parameter int PERIOD_CYCLES = 1000000,
  parameter int TOF_W         = 20
) (
  input  logic             SYS_CLK,
  input  logic             RSTbar,
  input  logic             ON,
  input  logic             MATCH,
  input  logic             FIFO_FULL,
  output logic             TX_P,
  output logic             TX_N,
  output logic             CAPTURE_EN,
  output logic             FIFO_CLR,
  output logic [TOF_W-1:0] TOF,
  output logic             TOF_VALID,
  output logic             TIMEOUT,
  output logic             OVERFLOW,
  output logic [2:0]       STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BURST   = 3'd1,
    S_BLANK   = 3'd2,
    S_LISTEN  = 3'd3,
    S_HOLDOFF = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int BURST_END = 2 * BURST_PULSES * HALF_CYC;
  localparam int TONE_W    = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  localparam logic [TOF_W-1:0]  BURST_LAST  = TOF_W'(BURST_END - 1);
  localparam logic [TOF_W-1:0]  BLANK_LAST  = TOF_W'(BURST_END + BLANK_CYCLES - 1);
  localparam logic [TOF_W-1:0]  PERIOD_LAST = TOF_W'(PERIOD_CYCLES - 1);
  localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(HALF_CYC - 1);

  state_t            state_q, state_d;
  logic [TOF_W-1:0]  pcnt_q, pcnt_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic              phase_q, phase_d;
  logic              match_prev_q;
  logic [TOF_W-1:0]  tof_q, tof_d;
  logic              tx_p_q, tx_p_d;
  logic              tx_n_q, tx_n_d;
  logic              capture_en_q, capture_en_d;
  logic              fifo_clr_q, fifo_clr_d;
  logic              tof_valid_q, tof_valid_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              restart;
  logic              match_edge;

  assign match_edge = MATCH & ~match_prev_q;

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q + 1'b1;
    tone_d      = tone_q;
    phase_d     = phase_q;
    tof_d       = tof_q;
    overflow_d  = overflow_q;
    fifo_clr_d  = 1'b0;
    tof_valid_d = 1'b0;
    timeout_d   = 1'b0;
    restart     = 1'b0;

    case (state_q)
      S_IDLE: begin
        pcnt_d  = '0;
        restart = ON;
      end
      S_BURST: begin
        if (tone_q == TONE_LAST) begin
          tone_d  = '0;
          phase_d = ~phase_q;
        end else begin
          tone_d = tone_q + 1'b1;
        end
        if (pcnt_q == BURST_LAST) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (pcnt_q == BLANK_LAST) state_d = S_LISTEN;
      end
      S_LISTEN: begin
        if (match_edge) begin
          tof_d       = pcnt_q;
          tof_valid_d = 1'b1;
          state_d     = S_HOLDOFF;
        end else if (pcnt_q == PERIOD_LAST) begin
          timeout_d = 1'b1;
        end
        if (pcnt_q == PERIOD_LAST) restart = 1'b1;
      end
      S_HOLDOFF: begin
        if (pcnt_q == PERIOD_LAST) restart = 1'b1;
      end
      S_FAULT: begin
        pcnt_d = '0;
        if (!ON) begin
          state_d    = S_IDLE;
          overflow_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
      end
    endcase

    // A new ping starts with the tone high and the sample FIFO flushed.
    if (restart) begin
      state_d    = S_BURST;
      pcnt_d     = '0;
      tone_d     = '0;
      phase_d    = 1'b1;
      fifo_clr_d = 1'b1;
    end

    // Overflow beats run-enable, which beats any phase decision made above.
    if (FIFO_FULL && state_q != S_IDLE && state_q != S_FAULT) begin
      state_d     = S_FAULT;
      overflow_d  = 1'b1;
      pcnt_d      = '0;
      tof_d       = tof_q;
      fifo_clr_d  = 1'b0;
      tof_valid_d = 1'b0;
      timeout_d   = 1'b0;
    end else if (!ON && state_q != S_FAULT) begin
      state_d     = S_IDLE;
      pcnt_d      = '0;
      tof_d       = tof_q;
      fifo_clr_d  = 1'b0;
      tof_valid_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  assign tx_p_d       = (state_d == S_BURST) &  phase_d;
  assign tx_n_d       = (state_d == S_BURST) & ~phase_d;
  assign capture_en_d = (state_d == S_BLANK) | (state_d == S_LISTEN);

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      state_q      <= S_IDLE;
      pcnt_q       <= '0;
      tone_q       <= '0;
      phase_q      <= 1'b0;
      match_prev_q <= 1'b0;
      tof_q        <= '0;
      tx_p_q       <= 1'b0;
      tx_n_q       <= 1'b0;
      capture_en_q <= 1'b0;
      fifo_clr_q   <= 1'b0;
      tof_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      tone_q       <= tone_d;
      phase_q      <= phase_d;
      match_prev_q <= MATCH;
      tof_q        <= tof_d;
      tx_p_q       <= tx_p_d;
      tx_n_q       <= tx_n_d;
      capture_en_q <= capture_en_d;
      fifo_clr_q   <= fifo_clr_d;
      tof_valid_q  <= tof_valid_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
    end
  end

  assign TX_P       = tx_p_q;
  assign TX_N       = tx_n_q;
  assign CAPTURE_EN = capture_en_q;
  assign FIFO_CLR   = fifo_clr_q;
  assign TOF        = tof_q;
  assign TOF_VALID  = tof_valid_q;
  assign TIMEOUT    = timeout_q;
  assign OVERFLOW   = overflow_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Bench for ping_sequencer: ping-level reference model driven by directed and random stimulus.
module tb_ping_sequencer;

  localparam int HALF   = 2;
  localparam int PULSES = 3;
  localparam int BLANK  = 4;
  localparam int PERIOD = 40;
  localparam int TW     = 8;
  localparam int BE     = 2 * PULSES * HALF;

  logic          clk = 1'b0;
  logic          rst_n, on, match, full;
  logic          tx_p, tx_n, cap, clr, vld, tmo, ovf;
  logic [TW-1:0] tof;
  logic [2:0]    state;

  ping_sequencer #(
    .HALF_CYC(HALF), .BURST_PULSES(PULSES), .BLANK_CYCLES(BLANK),
    .PERIOD_CYCLES(PERIOD), .TOF_W(TW)
  ) dut (
    .SYS_CLK(clk), .RSTbar(rst_n), .ON(on), .MATCH(match), .FIFO_FULL(full),
    .TX_P(tx_p), .TX_N(tx_n), .CAPTURE_EN(cap), .FIFO_CLR(clr),
    .TOF(tof), .TOF_VALID(vld), .TIMEOUT(tmo), .OVERFLOW(ovf), .STATE(state)
  );

  always #5 clk = ~clk;

  // Reference model: a ping is just a cycle count plus a "detected" flag.
  bit m_run, m_fault, m_det, m_ovf, m_prev, e_clr, e_vld, e_to;
  int m_pcnt, m_tof;
  int n_checks = 0, n_err = 0;
  int cnt_vld, cnt_to, cnt_clr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t pcnt=%0d)", name, act, exp, $time, m_pcnt);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_fault = 0; m_det = 0; m_ovf = 0; m_prev = 0;
    e_clr = 0; e_vld = 0; e_to = 0; m_pcnt = 0; m_tof = 0;
  endtask

  task automatic model_step();
    bit edge_seen, listening;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_seen = match && !m_prev;
    m_prev = match;
    e_clr = 0; e_vld = 0; e_to = 0;
    if (m_fault) begin
      if (!on) begin m_fault = 0; m_ovf = 0; end
    end else if (m_run && full) begin
      m_fault = 1; m_ovf = 1; m_run = 0;
    end else if (!on) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1; m_pcnt = 0; m_det = 0; e_clr = 1;
    end else begin
      listening = !m_det && (m_pcnt >= BE + BLANK);
      if (listening && edge_seen) begin
        m_tof = m_pcnt; e_vld = 1; m_det = 1;
      end else if (listening && m_pcnt == PERIOD - 1) begin
        e_to = 1;
      end
      if (m_pcnt == PERIOD - 1) begin
        m_pcnt = 0; m_det = 0; e_clr = 1;
      end else begin
        m_pcnt++;
      end
    end
  endtask

  function automatic int exp_state();
    if (m_fault) return 5;
    if (!m_run) return 0;
    if (m_pcnt < BE) return 1;
    if (m_pcnt < BE + BLANK) return 2;
    return m_det ? 4 : 3;
  endfunction

  task automatic check_all();
    bit in_burst, hi;
    int st;
    st = exp_state();
    in_burst = m_run && (m_pcnt < BE);
    hi = ((m_pcnt / HALF) % 2) == 0;
    chk("state", state, st);
    chk("tx_p", tx_p, in_burst && hi);
    chk("tx_n", tx_n, in_burst && !hi);
    chk("capture_en", cap, (st == 2) || (st == 3));
    chk("fifo_clr", clr, e_clr);
    chk("tof_valid", vld, e_vld);
    chk("timeout", tmo, e_to);
    chk("tof", tof, m_tof);
    chk("overflow", ovf, m_ovf);
    cnt_vld += int'(vld);
    cnt_to  += int'(tmo);
    cnt_clr += int'(clr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int pc);
    for (int i = 0; i < 200; i++) begin
      if (m_run && m_pcnt == pc) return;
      cycle();
    end
    n_checks++;
    n_err++;
    $display("FAIL wait_for_pcnt actual=never required=%0d", pc);
  endtask

  task automatic clear_counts();
    cnt_vld = 0; cnt_to = 0; cnt_clr = 0;
  endtask

  initial begin
    logic [11:0] tx_seen;
    logic [11:0] tx_want;
    rst_n = 0; on = 0; match = 0; full = 0;
    model_reset();
    clear_counts();

    // 1. Reset held, then released with ON low.
    repeat (3) cycle();
    chk("rst_state", state, 0);
    chk("rst_tof", tof, 0);
    rst_n = 1;
    repeat (20) cycle();
    chk("idle_state", state, 0);
    chk("idle_tx_p", tx_p, 0);

    // 2. Free-running pings with no detection.
    on = 1;
    clear_counts();
    tx_seen = '0;
    for (int c = 0; c < 81; c++) begin
      cycle();
      if (c < BE) tx_seen[c] = tx_p;
    end
    tx_want = 12'h333;
    chk("burst_tx_pattern", tx_seen, tx_want);
    chk("free_run_timeouts", cnt_to, 2);
    chk("free_run_clears", cnt_clr, 3);

    // 3. Detection at pcnt 25.
    run_until(25);
    match = 1;
    clear_counts();
    cycle();
    match = 0;
    chk("tof_at_25", tof, 25);
    run_until(0);
    chk("det_valid_count", cnt_vld, 1);
    chk("det_timeout_count", cnt_to, 0);

    // 4. Edges outside LISTEN and a level already high are ignored; edge on last cycle.
    clear_counts();
    run_until(8);
    match = 1;
    cycle();
    match = 0;
    run_until(13);
    match = 1;
    run_until(30);
    cycle();
    match = 0;
    run_until(0);
    chk("ignored_timeout", cnt_to, 1);
    chk("ignored_valid", cnt_vld, 0);
    chk("ignored_tof_kept", tof, 25);
    run_until(39);
    match = 1;
    cycle();
    match = 0;
    chk("last_tof", tof, 39);
    chk("last_valid", vld, 1);
    chk("last_no_gap_state", state, 1);
    chk("last_no_gap_clr", clr, 1);

    // 5. Overflow coinciding with a detect edge.
    run_until(20);
    full = 1; match = 1;
    cycle();
    full = 0; match = 0;
    chk("fault_state", state, 5);
    chk("fault_overflow", ovf, 1);
    chk("fault_no_valid", vld, 0);
    chk("fault_tof_kept", tof, 39);
    repeat (100) cycle();
    chk("fault_held", state, 5);
    on = 0;
    cycle();
    chk("fault_exit_state", state, 0);
    chk("fault_exit_ovf", ovf, 0);
    on = 1;
    cycle();
    chk("fault_restart", state, 1);

    // 6. ON dropped mid-burst.
    run_until(5);
    on = 0;
    cycle();
    chk("off_state", state, 0);
    chk("off_tx_p", tx_p, 0);
    chk("off_timeout", tmo, 0);
    repeat (3) cycle();
    on = 1;
    cycle();
    chk("reon_clr", clr, 1);
    chk("reon_tx_p", tx_p, 1);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      on   = ($urandom_range(0, 149) != 0);
      full = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) match = ~match;
      cycle();
    end

    // Asynchronous reset in the middle of LISTEN.
    full = 0; match = 0; on = 0;
    cycle();
    on = 1;
    run_until(20);
    #2 rst_n = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_cap", cap, 0);
    chk("arst_tx", {tx_p, tx_n}, 0);
    chk("arst_pulses", {clr, vld, tmo}, 0);
    chk("arst_tof", tof, 0);
    chk("arst_ovf", ovf, 0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1;
    repeat (60) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
